// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg: shared state encoding and default widths for the counter sequencer
package cnt_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int WIDTH_DEF = 4;
  localparam int PASS_W_DEF = 8;
endpackage

// File: rtl/cnt_pass_tracker.sv
// cnt_pass_tracker: saturating rollover counter; last_pass flags that the next rollover completes the command
module cnt_pass_tracker import cnt_seq_pkg::*; #(
  parameter int PASS_W = PASS_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              inc,
  input  logic [PASS_W-1:0] passes_eff,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              last_pass
);
  logic [PASS_W:0] nxt;
  assign nxt = {1'b0, pass_cnt} + 1'b1;
  assign last_pass = nxt == {1'b0, passes_eff};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) pass_cnt <= '0;
    else if (clear) pass_cnt <= '0;
    else if (inc && pass_cnt != '1) pass_cnt <= nxt[PASS_W-1:0];
endmodule

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: command sequencer that loads an up/down counter and waits for a number of rollovers
module cnt_seq_ctrl import cnt_seq_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PASS_W = PASS_W_DEF,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_load,
  input  logic              cmd_down,
  input  logic [PASS_W-1:0] cmd_passes,
  input  logic              abort,
  output logic              cnt_load_en,
  output logic [WIDTH-1:0]  cnt_load,
  output logic              cnt_down,
  input  logic              cnt_rollover,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [PASS_W-1:0] pass_cnt
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] load_q;
  logic down_q;
  logic [PASS_W-1:0] passes_q;
  logic aborted_q;
  logic accept, stop, last_pass;
  assign accept = cmd_valid && state == IDLE;
  assign stop = abort && (state == LOAD || state == RUN);
  always_comb
    state_nxt = stop ? IDLE :
                state == IDLE ? (cmd_valid ? LOAD : IDLE) :
                state == LOAD ? RUN :
                state == RUN ? (cnt_rollover && last_pass ? DONE : RUN) : IDLE;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      load_q <= '0;
      down_q <= 1'b0;
      passes_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state <= state_nxt;
      aborted_q <= stop;
      if (accept) begin
        load_q <= cmd_load;
        down_q <= cmd_down;
        passes_q <= cmd_passes == '0 ? PASS_W'(1) : cmd_passes;
      end
    end
  cnt_pass_tracker #(.PASS_W(PASS_W)) u_trk (
    .clk(clk),
    .rstn(rstn),
    .clear(accept),
    .inc(state == RUN && cnt_rollover && !abort),
    .passes_eff(passes_q),
    .pass_cnt(pass_cnt),
    .last_pass(last_pass)
  );
  assign cmd_ready = state == IDLE;
  assign busy = state == LOAD || state == RUN;
  assign done = state == DONE;
  assign aborted = aborted_q;
  assign cnt_load_en = state != RUN;
  assign cnt_load = state == LOAD ? load_q : IDLE_VAL;
  assign cnt_down = busy && down_q;
endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl: directed and random commands against a modelled counter, outcomes predicted per command
module tb_cnt_seq_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [3:0] cmd_load = '0;
  logic cmd_down = 1'b0;
  logic [7:0] cmd_passes = '0;
  logic abort = 1'b0;
  logic cnt_load_en;
  logic [3:0] cnt_load;
  logic cnt_down;
  logic cnt_rollover;
  logic busy, done, aborted;
  logic [7:0] pass_cnt;
  logic [3:0] cnt;
  logic roll;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cnt_seq_ctrl #(.WIDTH(4), .PASS_W(8), .IDLE_VAL(4'h0)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_down(cmd_down), .cmd_passes(cmd_passes),
    .abort(abort), .cnt_load_en(cnt_load_en), .cnt_load(cnt_load),
    .cnt_down(cnt_down), .cnt_rollover(cnt_rollover), .busy(busy),
    .done(done), .aborted(aborted), .pass_cnt(pass_cnt)
  );

  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= '0;
      roll <= 1'b0;
    end else begin
      cnt <= cnt_load_en ? cnt_load : cnt_down ? cnt - 4'd1 : cnt + 4'd1;
      roll <= !cnt_load_en && (cnt_down ? cnt == 4'h0 : cnt == 4'hF);
    end
  assign cnt_rollover = roll;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [3:0] ld, input logic dn, input logic [7:0] ps,
                         input int ab_seen, input bit ab_on_roll, input bit hold);
    int peff;
    int seen;
    bit fin;
    bit ab;
    logic r;
    peff = (ps == 8'd0) ? 1 : int'(ps);
    seen = 0;
    fin = 1'b0;
    chk("idle_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_load_en", cnt_load_en, 1);
    chk("idle_load", cnt_load, 0);
    chk("idle_done", done, 0);
    cmd_valid = 1'b1;
    cmd_load = ld;
    cmd_down = dn;
    cmd_passes = ps;
    abort = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    abort = 1'b0;
    cmd_load = 4'($urandom);
    cmd_down = 1'($urandom);
    cmd_passes = 8'($urandom);
    chk("load_busy", busy, 1);
    chk("load_ready", cmd_ready, 0);
    chk("load_en", cnt_load_en, 1);
    chk("load_val", cnt_load, ld);
    chk("load_down", cnt_down, dn);
    chk("load_pass", pass_cnt, 0);
    chk("load_aborted", aborted, 0);
    chk("load_done", done, 0);
    if (ab_seen == -2) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("labort_aborted", aborted, 1);
      chk("labort_done", done, 0);
      chk("labort_pass", pass_cnt, 0);
      chk("labort_ready", cmd_ready, 1);
      chk("labort_busy", busy, 0);
      return;
    end
    @(negedge clk);
    for (int c = 0; c < 20 * peff + 20 && !fin; c++) begin
      chk("run_busy", busy, 1);
      chk("run_load_en", cnt_load_en, 0);
      chk("run_down", cnt_down, dn);
      chk("run_pass", pass_cnt, seen);
      chk("run_done", done, 0);
      chk("run_ready", cmd_ready, 0);
      r = cnt_rollover;
      ab = (seen == ab_seen) && (r == ab_on_roll);
      abort = ab;
      @(negedge clk);
      abort = 1'b0;
      if (ab) begin
        chk("abort_aborted", aborted, 1);
        chk("abort_done", done, 0);
        chk("abort_pass", pass_cnt, seen);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_load_en", cnt_load_en, 1);
        chk("abort_load", cnt_load, 0);
        fin = 1'b1;
      end else if (r) begin
        seen++;
        if (seen == peff) begin
          chk("done_pulse", done, 1);
          chk("done_pass", pass_cnt, peff);
          chk("done_busy", busy, 0);
          chk("done_load_en", cnt_load_en, 1);
          chk("done_load", cnt_load, 0);
          chk("done_ready", cmd_ready, 0);
          abort = 1'($urandom_range(0, 1));
          @(negedge clk);
          abort = 1'b0;
          chk("post_done", done, 0);
          chk("post_ready", cmd_ready, 1);
          chk("post_aborted", aborted, 0);
          chk("post_pass", pass_cnt, peff);
          fin = 1'b1;
        end
      end
    end
    chk("timeout", fin, 1);
  endtask

  initial begin
    #12 rstn = 1'b0;
    #1;
    chk("rst_load_en", cnt_load_en, 1);
    chk("rst_load", cnt_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_down", cnt_down, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_cmd(4'hD, 1'b0, 8'd2, -1, 1'b0, 1'b0);
    run_cmd(4'h2, 1'b1, 8'd0, -1, 1'b0, 1'b0);
    run_cmd(4'h5, 1'b0, 8'd3, 1, 1'b0, 1'b0);
    run_cmd(4'h7, 1'b1, 8'd2, 1, 1'b1, 1'b0);
    run_cmd(4'h0, 1'b0, 8'd1, -2, 1'b0, 1'b0);
    run_cmd(4'h0, 1'b1, 8'd1, 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      run_cmd(4'($urandom), 1'($urandom), 8'd1, -1, 1'b0, 1'b1);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] ps;
      int pe;
      int sel;
      ps = 8'($urandom_range(0, 3));
      pe = (ps == 8'd0) ? 1 : int'(ps);
      sel = int'($urandom_range(0, 3));
      if (sel < 2) run_cmd(4'($urandom), 1'($urandom), ps, -1, 1'b0, 1'b0);
      else if (sel == 2) run_cmd(4'($urandom), 1'($urandom), ps, -2, 1'b0, 1'b0);
      else run_cmd(4'($urandom), 1'($urandom), ps, int'($urandom_range(0, pe - 1)),
                   1'($urandom_range(0, 1)), 1'b0);
    end
    run_cmd(4'h3, 1'b0, 8'hFF, -1, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    cmd_load = 4'h9;
    cmd_down = 1'b1;
    cmd_passes = 8'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("mrst_load_en", cnt_load_en, 1);
    chk("mrst_load", cnt_load, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", cmd_ready, 1);
    chk("mrst_pass", pass_cnt, 0);
    chk("mrst_down", cnt_down, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("mrst_done", done, 0);
    chk("mrst_aborted", aborted, 0);
    run_cmd(4'hE, 1'b0, 8'd1, -1, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
